// File: rtl/min_max_pkg.sv
// rtl/min_max_pkg.sv - shared types and helpers for the min/max PWM LED bar display
package min_max_pkg;

  typedef enum logic [1:0] {
    COM_NORMAL = 2'b00,
    COM_LINEAR = 2'b01,
    COM_OFF    = 2'b10,
    COM_ON     = 2'b11
  } com_t;

  // Display stays dark until the first captured command.
  localparam com_t COM_RESET = COM_OFF;

  // Inclusive range test done in int so that bound+1 never wraps.
  function automatic logic in_range(int idx, int lo, int hi);
    return (idx >= lo) && (idx <= hi);
  endfunction

endpackage

// File: rtl/min_max_peak_hold.sv
// rtl/min_max_peak_hold.sv - peak register with timed decay toward the current value
module min_max_peak_hold #(
  parameter int VALSIZE     = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hold_en_i,
  input  logic [VALSIZE-1:0] val_i,
  output logic [VALSIZE-1:0] peak_o
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] hold_cnt;

  // A new peak takes priority over an expiring hold timer and restarts it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      peak_o   <= '0;
      hold_cnt <= '0;
    end else if (!hold_en_i) begin
      peak_o   <= val_i;
      hold_cnt <= '0;
    end else if (val_i > peak_o) begin
      peak_o   <= val_i;
      hold_cnt <= '0;
    end else if (hold_cnt == LAST) begin
      hold_cnt <= '0;
      if (peak_o > val_i) peak_o <= peak_o - 1'b1;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/min_max_pwm_disp.sv
// rtl/min_max_pwm_disp.sv - registered min/max LED bar with PWM dimming, peak marker and range error
module min_max_pwm_disp
  import min_max_pkg::*;
#(
  parameter int VALSIZE     = 4,
  parameter int PWM_BITS    = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [1:0]              com_i,
  input  logic [VALSIZE-1:0]      min_i,
  input  logic [VALSIZE-1:0]      max_i,
  input  logic [VALSIZE-1:0]      val_i,
  input  logic [PWM_BITS-1:0]     duty_i,
  input  logic                    hold_en_i,
  output logic [2**VALSIZE-1:0]   leds_o,
  output logic [VALSIZE-1:0]      peak_o,
  output logic                    range_err_o
);

  localparam int NLEDS = 2**VALSIZE;

  typedef logic [VALSIZE-1:0] val_t;
  typedef logic [NLEDS-1:0]   led_t;

  com_t                com_q;
  val_t                min_q, max_q, val_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  led_t                leds_next;
  logic                err_next;
  logic                dim;

  min_max_peak_hold #(
    .VALSIZE    (VALSIZE),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_peak (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_en_i(hold_en_i),
    .val_i    (val_q),
    .peak_o   (peak_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      com_q       <= COM_RESET;
      min_q       <= '0;
      max_q       <= '0;
      val_q       <= '0;
      pwm_cnt     <= '0;
      leds_o      <= '0;
      range_err_o <= 1'b0;
    end else begin
      if (valid_i) begin
        com_q <= com_t'(com_i);
        min_q <= min_i;
        max_q <= max_i;
        val_q <= val_i;
      end
      pwm_cnt     <= pwm_cnt + 1'b1;
      leds_o      <= leds_next;
      range_err_o <= err_next;
    end
  end

  // Bar decode: solid from min to value, PWM-dimmed from value+1 to max.
  always_comb begin
    leds_next = '0;
    err_next  = 1'b0;
    dim       = (pwm_cnt < duty_i);
    case (com_q)
      COM_NORMAL: begin
        if (min_q > max_q) begin
          err_next = 1'b1;
        end else if (val_q >= min_q && val_q <= max_q) begin
          for (int i = 0; i < NLEDS; i++) begin
            if (in_range(i, int'(min_q), int'(val_q)))
              leds_next[i] = 1'b1;
            else if (in_range(i, int'(val_q) + 1, int'(max_q)))
              leds_next[i] = dim;
          end
          if (hold_en_i && peak_o >= min_q && peak_o <= max_q)
            leds_next[peak_o] = 1'b1;
        end
      end
      COM_LINEAR: begin
        for (int i = 0; i < NLEDS; i++)
          leds_next[i] = in_range(i, 0, int'(val_q));
        if (hold_en_i) leds_next[peak_o] = 1'b1;
      end
      COM_ON:  leds_next = '1;
      default: leds_next = '0;
    endcase
  end

endmodule

// File: tb/tb_min_max_pwm_disp.sv
// tb/tb_min_max_pwm_disp.sv - scoreboard bench with a behavioural model of the LED bar display
module tb_min_max_pwm_disp;

  localparam int VS = 4;
  localparam int PB = 4;
  localparam int HC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [1:0]    com = 2'b00;
  logic [VS-1:0] mn = '0, mx = '0, val = '0;
  logic [PB-1:0] duty = '0;
  logic          hold_en = 1'b0;
  logic [15:0]   leds;
  logic [VS-1:0] peak;
  logic          range_err;

  typedef struct packed {
    logic [15:0]   leds;
    logic [VS-1:0] peak;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  // model state
  int m_c = 2, m_mn = 0, m_mx = 0, m_v = 0, m_peak = 0, m_hold = 0, m_pwm = 0;

  min_max_pwm_disp #(.VALSIZE(VS), .PWM_BITS(PB), .HOLD_CYCLES(HC)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .com_i(com), .min_i(mn), .max_i(mx),
    .val_i(val), .duty_i(duty), .hold_en_i(hold_en), .leds_o(leds), .peak_o(peak),
    .range_err_o(range_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_leds(int c, int lo, int hi, int v, int pk, bit hen, bit dm);
    logic [15:0] r;
    r = '0;
    if (c == 0) begin
      if (lo <= hi && v >= lo && v <= hi) begin
        for (int i = 0; i < 16; i++)
          if (i >= lo && i <= v) r[i] = 1'b1;
          else if (i > v && i <= hi) r[i] = dm;
        if (hen && pk >= lo && pk <= hi) r[pk] = 1'b1;
      end
    end else if (c == 1) begin
      for (int i = 0; i <= v; i++) r[i] = 1'b1;
      if (hen) r[pk] = 1'b1;
    end else if (c == 3) begin
      r = 16'hFFFF;
    end
    return r;
  endfunction

  // Reference model: advances at each edge and queues what the outputs must show after it.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      m_c = 2; m_mn = 0; m_mx = 0; m_v = 0; m_peak = 0; m_hold = 0; m_pwm = 0;
      e = '0;
    end else begin
      e.leds = model_leds(m_c, m_mn, m_mx, m_v, m_peak, hold_en, m_pwm < int'(duty));
      e.err  = (m_c == 0) && (m_mn > m_mx);
      if (!hold_en || m_v > m_peak) begin
        m_peak = m_v; m_hold = 0;
      end else if (m_hold == HC - 1) begin
        m_hold = 0;
        if (m_peak > m_v) m_peak = m_peak - 1;
      end else begin
        m_hold = m_hold + 1;
      end
      e.peak = VS'(m_peak);
      m_pwm = (m_pwm + 1) % (1 << PB);
      if (valid) begin
        m_c = int'(com); m_mn = int'(mn); m_mx = int'(mx); m_v = int'(val);
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: one expected entry per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty t=%0t: no expected entry queued", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (leds !== e.leds) begin
          errors++;
          $display("FAIL leds t=%0t: got %h expected %h", $time, leds, e.leds);
        end
        checks++;
        if (peak !== e.peak) begin
          errors++;
          $display("FAIL peak t=%0t: got %0d expected %0d", $time, peak, e.peak);
        end
        checks++;
        if (range_err !== e.err) begin
          errors++;
          $display("FAIL range_err t=%0t: got %b expected %b", $time, range_err, e.err);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic capture(logic [1:0] c, int lo, int hi, int v);
    com = c; mn = VS'(lo); mx = VS'(hi); val = VS'(v); valid = 1'b1;
    tick(1);
    valid = 1'b0;
  endtask

  initial begin
    int guard;
    // reset held two edges, then dark until first capture
    tick(2);
    rst = 1'b0;
    tick(4);
    // normal bar with PWM dimming, then duty 0
    duty = 4'd4;
    capture(2'b00, 3, 12, 8);
    tick(40);
    duty = 4'd0;
    tick(20);
    // bounds
    duty = 4'd8;
    capture(2'b00, 0, 15, 15);
    tick(5);
    capture(2'b00, 9, 4, 0);
    tick(3);
    capture(2'b00, 2, 6, 10);
    tick(3);
    capture(2'b11, 0, 0, 0);
    tick(3);
    // peak decay in linear mode
    hold_en = 1'b1;
    capture(2'b01, 0, 0, 12);
    tick(3);
    capture(2'b01, 0, 0, 5);
    tick(70);
    // new peak arriving on the decay-expiry cycle
    capture(2'b01, 0, 0, 12);
    tick(2);
    capture(2'b01, 0, 0, 5);
    tick(3);
    guard = 0;
    while (m_hold != HC - 2 && guard < 40) begin
      tick(1);
      guard++;
    end
    if (guard >= 40) begin
      errors++;
      $display("FAIL collision_setup: hold counter never reached %0d", HC - 2);
    end
    capture(2'b01, 0, 0, 14);
    tick(20);
    // peak marker in normal mode
    capture(2'b00, 4, 13, 9);
    tick(10);
    // inputs changed without valid are ignored; mid-run reset
    hold_en = 1'b0;
    capture(2'b01, 0, 0, 3);
    com = 2'b11; val = 4'd9; mn = 4'd1;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    // randomized operation
    for (int k = 0; k < 500; k++) begin
      valid = ($urandom_range(0, 3) == 0);
      com   = 2'($urandom_range(0, 3));
      mn    = VS'($urandom_range(0, 15));
      mx    = VS'($urandom_range(0, 15));
      val   = VS'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) duty = PB'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) hold_en = ~hold_en;
      rst   = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    rst = 1'b0; valid = 1'b0;
    tick(3);
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
